// File: rtl/cla_result_accumulator.sv
// Multi-beat accumulator behind the carry-lookahead adder: sums `count` adder results into an ACC_W register.
// Optional build macro CLA_ACC_SATURATE_EN clamps the total at all-ones on overflow instead of wrapping.
module cla_result_accumulator #(
  parameter int N     = 8,
  parameter int ACC_W = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N:0]       in_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf,
  output logic             busy
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // The ready/valid driven here come from the registered state only, never from the partner's signal.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] remaining, remaining_next;
  logic [ACC_W-1:0] acc, acc_next;
  logic             ovf, ovf_next;
  logic [ACC_W:0]   sum_ext;

  // Bit ACC_W of the widened sum is the carry out of the accumulator.
  assign sum_ext = {1'b0, acc} + {{(ACC_W - N){1'b0}}, in_result};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      remaining <= '0;
      acc       <= '0;
      ovf       <= 1'b0;
    end else begin
      state     <= state_next;
      remaining <= remaining_next;
      acc       <= acc_next;
      ovf       <= ovf_next;
    end
  end

  always_comb begin
    state_next     = state;
    remaining_next = remaining;
    acc_next       = acc;
    ovf_next       = ovf;
    case (state)
      ST_IDLE: begin
        if (start) begin
          remaining_next = count;
          acc_next       = '0;
          ovf_next       = 1'b0;
          state_next     = (count == '0) ? ST_DONE : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (in_valid) begin
          remaining_next = remaining - CNT_W'(1);
          if (sum_ext[ACC_W]) ovf_next = 1'b1;
`ifdef CLA_ACC_SATURATE_EN
          acc_next = (sum_ext[ACC_W] || ovf) ? '1 : sum_ext[ACC_W-1:0];
`else
          acc_next = sum_ext[ACC_W-1:0];
`endif
          if (remaining == CNT_W'(1)) state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign in_ready  = (state == ST_ACCUM);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state == ST_ACCUM) || (state == ST_DONE);
  assign out_sum   = acc;
  assign out_ovf   = ovf;

endmodule
